// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: default width and mode encodings.
// Optional synchronous clear is enabled by defining COUNTER_CLR_EN.
package counter_pkg;

    localparam int unsigned COUNTER_DEF_WIDTH = 4;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

endpackage : counter_pkg

// File: rtl/counter.sv
// Parameterised up/down counter with synchronous load, count enable and a sticky
// carry/borrow-out. Defining COUNTER_CLR_EN adds a synchronous clear input CLR.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic             M,
    input  logic             LD,
    input  logic             CE,
`ifdef COUNTER_CLR_EN
    input  logic             CLR,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sticky_q, sticky_d;
    logic             tc;

    // Terminal count depends on the live mode so a direction flip is seen at once.
    always_comb begin
        tc = 1'b0;
        if (M == MODE_UP) begin
            tc = (q_q == {WIDTH{1'b1}});
        end else begin
            tc = (q_q == {WIDTH{1'b0}});
        end
    end

    always_comb begin
        q_d      = q_q;
        sticky_d = sticky_q;
`ifdef COUNTER_CLR_EN
        if (CLR) begin
            q_d      = '0;
            sticky_d = 1'b0;
        end else
`endif
        if (LD) begin
            q_d      = D;
            sticky_d = 1'b0;
        end else if (CE) begin
            q_d = (M == MODE_DOWN) ? (q_q - One) : (q_q + One);
            if (tc) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            q_q      <= '0;
            sticky_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            sticky_q <= sticky_d;
        end
    end

    assign Q  = q_q;
    assign CO = tc | sticky_q;

endmodule : counter

// File: tb/tb_counter.sv
// Directed self-checking bench for the 4-bit counter: reset, up/down wrap,
// sticky carry, load, hold, live mode change and load priority.
module tb_counter;

    logic       clk;
    logic       rst_n;
    logic       m;
    logic       ld;
    logic       ce;
    logic       clr;
    logic [3:0] d;
    logic [3:0] q;
    logic       co;

    int n_cmp  = 0;
    int n_fail = 0;

    counter #(.WIDTH(4)) dut (
        .CLK  (clk),
        .RST_ (rst_n),
        .M    (m),
        .LD   (ld),
        .CE   (ce),
`ifdef COUNTER_CLR_EN
        .CLR  (clr),
`endif
        .D    (d),
        .Q    (q),
        .CO   (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m = 1'b0; ld = 1'b0; ce = 1'b0; clr = 1'b0; d = 4'd0;
        #1;
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: got q=%0d co=%b want q=0 co=0", q, co);
        end
        step(); step();
        rst_n = 1'b1;
        ce = 1'b1;
        step(); step(); step();
        n_cmp++;
        if (q !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_precount: got q=%0d want 3", q);
        end
        // Drop reset away from any clock edge; clear must be immediate.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got q=%0d co=%b want q=0 co=0", q, co);
        end
        step();
        n_cmp++;
        if (q !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_held: got q=%0d want 0", q);
        end
        ce = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_up_count();
        m = 1'b0; ce = 1'b1; ld = 1'b0;
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL up_start: got q=%0d co=%b want q=0 co=0", q, co);
        end
        for (int i = 1; i < 16; i++) begin
            step();
            n_cmp++;
            if (q !== 4'(i) || co !== (i == 15)) begin
                n_fail++;
                $display("FAIL up_step[%0d]: got q=%0d co=%b want q=%0d co=%b",
                         i, q, co, i, (i == 15));
            end
        end
        step();
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL up_wrap: got q=%0d co=%b want q=0 co=1", q, co);
        end
    endtask

    task automatic test_down_count();
        m = 1'b1;
        #1;
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL down_start: got q=%0d co=%b want q=0 co=1", q, co);
        end
        for (int i = 15; i >= 1; i--) begin
            step();
            n_cmp++;
            if (q !== 4'(i) || co !== 1'b1) begin
                n_fail++;
                $display("FAIL down_step[%0d]: got q=%0d co=%b want q=%0d co=1", i, q, co, i);
            end
        end
    endtask

    task automatic test_load_clears_sticky();
        ld = 1'b1; d = 4'b1010; ce = 1'b1; m = 1'b1;
        step();
        ld = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd10 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL load_value: got q=%0d co=%b want q=10 co=0", q, co);
        end
        for (int i = 9; i >= 1; i--) begin
            step();
            n_cmp++;
            if (q !== 4'(i) || co !== 1'b0) begin
                n_fail++;
                $display("FAIL load_down[%0d]: got q=%0d co=%b want q=%0d co=0", i, q, co, i);
            end
        end
        step();
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL load_tc: got q=%0d co=%b want q=0 co=1", q, co);
        end
        for (int i = 15; i >= 5; i--) begin
            step();
            n_cmp++;
            if (q !== 4'(i) || co !== 1'b1) begin
                n_fail++;
                $display("FAIL load_wrap[%0d]: got q=%0d co=%b want q=%0d co=1", i, q, co, i);
            end
        end
    endtask

    task automatic test_hold();
        // From q=5 with sticky set, count up to 7 then hold.
        m = 1'b0; ce = 1'b1;
        step(); step();
        n_cmp++;
        if (q !== 4'd7 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_setup: got q=%0d co=%b want q=7 co=1", q, co);
        end
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (q !== 4'd7 || co !== 1'b1) begin
                n_fail++;
                $display("FAIL hold[%0d]: got q=%0d co=%b want q=7 co=1", i, q, co);
            end
        end
    endtask

    task automatic test_mode_change();
        ld = 1'b1; d = 4'd0; m = 1'b0; ce = 1'b0;
        step();
        ld = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_up_zero: got q=%0d co=%b want q=0 co=0", q, co);
        end
        m = 1'b1;
        #1;
        n_cmp++;
        if (co !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_flip_down: got co=%b want 1", co);
        end
        m = 1'b0;
        #1;
        n_cmp++;
        if (co !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_flip_up: got co=%b want 0", co);
        end
        m = 1'b1; ce = 1'b1;
        step(); step();
        m = 1'b0; ce = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd14 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_sticky_kept: got q=%0d co=%b want q=14 co=1", q, co);
        end
    endtask

    task automatic test_load_priority();
        ld = 1'b1; d = 4'd15; m = 1'b0; ce = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'd15 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_setup: got q=%0d co=%b want q=15 co=1", q, co);
        end
        ld = 1'b1; ce = 1'b1; d = 4'b0011;
        step();
        n_cmp++;
        if (q !== 4'd3 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_load: got q=%0d co=%b want q=3 co=0", q, co);
        end
        ld = 1'b0; ce = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'd3 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_no_sticky: got q=%0d co=%b want q=3 co=0", q, co);
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive loads then an immediate count from the last loaded value.
        ld = 1'b1; ce = 1'b1; m = 1'b0;
        d = 4'd9;
        step();
        d = 4'd12;
        step();
        n_cmp++;
        if (q !== 4'd12) begin
            n_fail++;
            $display("FAIL b2b_load: got q=%0d want 12", q);
        end
        ld = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'd13 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got q=%0d co=%b want q=13 co=0", q, co);
        end
        ce = 1'b0;
    endtask

`ifdef COUNTER_CLR_EN
    task automatic test_clr();
        ld = 1'b1; d = 4'd15; m = 1'b0; ce = 1'b1;
        step();
        ld = 1'b0;
        step();
        clr = 1'b1; ld = 1'b1; d = 4'd6;
        step();
        clr = 1'b0; ld = 1'b0; ce = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd0 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL clr: got q=%0d co=%b want q=0 co=0", q, co);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_load_clears_sticky();
        test_hold();
        test_mode_change();
        test_load_priority();
        test_back_to_back();
`ifdef COUNTER_CLR_EN
        test_clr();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_counter
